// File: rtl/crc_pkg.sv
// crc_pkg
// Shared CRC definitions: standard polynomial/init constants, the stream
// engine state enum and the width-generic MSB-first CRC step function used
// by every CRC datapath block.
package crc_pkg;

  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } crc_state_e;

  // Folds data_w bits of data (bit data_w-1 first) into a crc_w-bit register.
  // Both register and data are left-aligned inside 64 bits so the feedback
  // bit is always bit 63 and bits shifted past the top simply fall away,
  // which avoids variable bit indexing and explicit masking.
  function automatic logic [63:0] crc_step(input logic [63:0] crc,
                                           input logic [63:0] data,
                                           input logic [63:0] poly,
                                           input int          crc_w,
                                           input int          data_w);
    logic [63:0] r;
    logic [63:0] d;
    logic [63:0] p;
    logic        fb;
    r = crc << (64 - crc_w);
    p = poly << (64 - crc_w);
    d = data << (64 - data_w);
    for (int i = 0; i < 64; i++) begin
      if (i < data_w) begin
        fb = r[63] ^ d[63];
        r  = (r << 1) ^ (fb ? p : 64'd0);
        d  = d << 1;
      end
    end
    return r >> (64 - crc_w);
  endfunction

endpackage

// File: rtl/crc_step_comb.sv
// crc_step_comb
// Combinational wrapper around crc_pkg::crc_step for a fixed CRC width,
// beat width and polynomial. With CRC_W=16, DATA_W=8, POLY=16'h1021 it is
// the classic CRC-16/CCITT byte step.
// Ports:
//   crc      - current CRC register value
//   data     - beat payload, bit DATA_W-1 processed first
//   next_crc - register value after folding in the whole beat
module crc_step_comb
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 16,
  parameter int               DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = 16'h1021
) (
  input  logic [CRC_W-1:0]  crc,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  next_crc
);

  assign next_crc = CRC_W'(crc_step(64'(crc), 64'(data), 64'(POLY), CRC_W, DATA_W));

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine
// Folds a framed stream into a CRC, DATA_W bits per accepted beat, and
// presents the finished CRC (register ^ XOR_OUT) and the beat count on a
// valid/ready result port. One result is buffered; while it is pending the
// input side is closed.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   clr                 - synchronous abort of the frame / pending result
//   in_valid, in_ready  - input beat handshake
//   in_data, in_last    - beat payload and end-of-frame marker
//   out_valid, out_ready- result handshake
//   out_crc, out_len    - final CRC and saturating beat count of the frame
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 16'h1021,
  parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000,
  parameter int               DATA_W  = 8,
  parameter int               LEN_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc,
  output logic [LEN_W-1:0]  out_len
);

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d, crc_next;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CRC_W-1:0] out_crc_q, out_crc_d;
  logic [LEN_W-1:0] out_len_q, out_len_d;

  crc_step_comb #(
    .CRC_W (CRC_W),
    .DATA_W(DATA_W),
    .POLY  (POLY)
  ) u_step (
    .crc     (crc_q),
    .data    (in_data),
    .next_crc(crc_next)
  );

  // The beat counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);

  // Handshake outputs come straight from the state register, so in_ready
  // never depends combinationally on in_valid or out_ready.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign out_crc   = out_crc_q;
  assign out_len   = out_len_q;

  // Next-state logic. clr overrides everything, including a result being
  // taken in the same cycle, and a beat offered alongside clr is dropped.
  // The result registers are left alone by clr; only rst zeroes them.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    out_crc_d = out_crc_q;
    out_len_d = out_len_q;
    if (clr) begin
      state_d = ST_ACCUM;
      crc_d   = INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid) begin
            crc_d = crc_next;
            cnt_d = cnt_inc;
            if (in_last) begin
              out_crc_d = crc_next ^ XOR_OUT;
              out_len_d = cnt_inc;
              state_d   = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_ACCUM;
            crc_d   = INIT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_ACCUM;
          crc_d   = INIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      crc_q     <= INIT;
      cnt_q     <= '0;
      out_crc_q <= '0;
      out_len_q <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      out_crc_q <= out_crc_d;
      out_len_q <= out_len_d;
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine
// Bench for crc_stream_engine. Four byte-wide instances (default CRC-16,
// INIT=0, CRC-32, LEN_W=3) share one input stream; a 16-bit-beat instance
// has its own stream. A byte-level reference model follows every instance
// and one negedge process compares all outputs each cycle, with literal
// reference values pinned on selected frames.
module tb_crc_stream_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b1;

  logic        dut_in_ready, dut_out_valid;
  logic [15:0] dut_crc, dut_len;
  logic        i0_in_ready, i0_out_valid;
  logic [15:0] i0_crc, i0_len;
  logic        c32_in_ready, c32_out_valid;
  logic [31:0] c32_crc;
  logic [15:0] c32_len;
  logic        l3_in_ready, l3_out_valid;
  logic [15:0] l3_crc;
  logic [2:0]  l3_len;

  logic        w_valid = 1'b0;
  logic        w_last = 1'b0;
  logic [15:0] w_data = 16'h0000;
  logic        w_out_ready = 1'b1;
  logic        w_in_ready, w_out_valid;
  logic [15:0] w_crc, w_len;

  always #5 clk = ~clk;

  crc_stream_engine u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(dut_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(dut_out_valid),
    .out_ready(out_ready), .out_crc(dut_crc), .out_len(dut_len)
  );

  crc_stream_engine #(.INIT(16'h0000)) u_init0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(i0_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(i0_out_valid),
    .out_ready(out_ready), .out_crc(i0_crc), .out_len(i0_len)
  );

  crc_stream_engine #(
    .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'h0)
  ) u_crc32 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(c32_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(c32_out_valid),
    .out_ready(out_ready), .out_crc(c32_crc), .out_len(c32_len)
  );

  crc_stream_engine #(.LEN_W(3)) u_len3 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(l3_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(l3_out_valid),
    .out_ready(out_ready), .out_crc(l3_crc), .out_len(l3_len)
  );

  crc_stream_engine #(.DATA_W(16)) u_w16 (
    .clk(clk), .rst(rst), .clr(1'b0), .in_valid(w_valid), .in_ready(w_in_ready),
    .in_data(w_data), .in_last(w_last), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_crc(w_crc), .out_len(w_len)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit eq_phase = 1'b0;

  // Literal expectations set by the stimulus for selected frames.
  bit          lit_en16 = 1'b0, lit_en_i0 = 1'b0, lit_en32 = 1'b0;
  bit          lit_en_len = 1'b0, lit_en_l3 = 1'b0;
  logic [63:0] lit_c16 = '0, lit_ci0 = '0, lit_c32 = '0;
  int          lit_len = 0, lit_l3 = 0;

  // Reference model state.
  logic [7:0]  m_q[$];
  bit          m_pending = 1'b0, m_zero = 1'b1;
  int          m_len = 0;
  logic [63:0] m_c16 = '0, m_ci0 = '0, m_c32 = '0;
  logic [7:0]  w_q[$];
  bit          w_pending = 1'b0, w_zero = 1'b1;
  int          w_mlen = 0;
  logic [63:0] w_mcrc = '0;
  logic [15:0] w_res[$];

  logic [7:0]  stim[0:63];
  int          rand_off[0:3];
  int          rand_len[0:3];

  // Byte-at-a-time CRC: XOR the byte into the top of the register, then
  // eight polynomial-division shifts.
  function automatic logic [63:0] model_crc(input logic [7:0] msg[$], input int w,
                                            input logic [63:0] poly,
                                            input logic [63:0] init,
                                            input logic [63:0] xorout);
    logic [63:0] r;
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    r = init & mask;
    foreach (msg[k]) begin
      r = r ^ ({56'd0, msg[k]} << (w - 8));
      for (int b = 0; b < 8; b++) begin
        if (((r >> (w - 1)) & 64'd1) != 64'd0) r = ((r << 1) ^ poly) & mask;
        else r = (r << 1) & mask;
      end
    end
    return (r ^ xorout) & mask;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are checked against the model state reached by
  // the previous edges, then the model absorbs the inputs the next edge sees.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("in_ready", 64'(dut_in_ready), 64'(!m_pending));
      checkOutput("out_valid", 64'(dut_out_valid), 64'(m_pending));
      checkOutput("i0_out_valid", 64'(i0_out_valid), 64'(m_pending));
      checkOutput("c32_out_valid", 64'(c32_out_valid), 64'(m_pending));
      checkOutput("l3_in_ready", 64'(l3_in_ready), 64'(!m_pending));
      if (m_pending) begin
        checkOutput("out_crc", 64'(dut_crc), m_c16);
        checkOutput("out_len", 64'(dut_len), 64'(m_len));
        checkOutput("i0_out_crc", 64'(i0_crc), m_ci0);
        checkOutput("c32_out_crc", 64'(c32_crc), m_c32);
        checkOutput("l3_out_len", 64'(l3_len), 64'((m_len > 7) ? 7 : m_len));
      end else if (m_zero) begin
        checkOutput("reset_out_crc", 64'(dut_crc), 64'd0);
        checkOutput("reset_out_len", 64'(dut_len), 64'd0);
        checkOutput("reset_c32_crc", 64'(c32_crc), 64'd0);
      end
      checkOutput("w16_in_ready", 64'(w_in_ready), 64'(!w_pending));
      checkOutput("w16_out_valid", 64'(w_out_valid), 64'(w_pending));
      if (w_pending) begin
        checkOutput("w16_out_crc", 64'(w_crc), w_mcrc);
        checkOutput("w16_out_len", 64'(w_len), 64'(w_mlen));
      end else if (w_zero) begin
        checkOutput("w16_reset_crc", 64'(w_crc), 64'd0);
      end

      if (rst || clr) begin
        m_pending = 1'b0;
        m_q.delete();
        if (rst) m_zero = 1'b1;
      end else if (!m_pending) begin
        if (in_valid) begin
          m_q.push_back(in_data);
          if (in_last) begin
            m_pending = 1'b1;
            m_zero    = 1'b0;
            m_len     = m_q.size();
            m_c16     = model_crc(m_q, 16, 64'h1021, 64'hFFFF, 64'h0);
            m_ci0     = model_crc(m_q, 16, 64'h1021, 64'h0, 64'h0);
            m_c32     = model_crc(m_q, 32, 64'h04C11DB7, 64'hFFFFFFFF, 64'h0);
            m_q.delete();
          end
        end
      end else if (out_ready) begin
        if (lit_en16)   checkOutput("lit_crc16", 64'(dut_crc), lit_c16);
        if (lit_en_len) checkOutput("lit_len", 64'(dut_len), 64'(lit_len));
        if (lit_en_i0)  checkOutput("lit_crc_init0", 64'(i0_crc), lit_ci0);
        if (lit_en32)   checkOutput("lit_crc32", 64'(c32_crc), lit_c32);
        if (lit_en_l3)  checkOutput("lit_len3", 64'(l3_len), 64'(lit_l3));
        if (eq_phase) begin
          if (w_res.size() == 0) checkOutput("eq_w16_result_available", 64'(w_res.size()), 64'd1);
          else checkOutput("eq_w16_vs_w8", 64'(dut_crc), 64'(w_res.pop_front()));
        end
        m_pending = 1'b0;
      end

      if (rst) begin
        w_pending = 1'b0;
        w_zero    = 1'b1;
        w_q.delete();
      end else if (!w_pending) begin
        if (w_valid) begin
          w_q.push_back(w_data[15:8]);
          w_q.push_back(w_data[7:0]);
          if (w_last) begin
            w_pending = 1'b1;
            w_zero    = 1'b0;
            w_mlen    = w_q.size() / 2;
            w_mcrc    = model_crc(w_q, 16, 64'h1021, 64'hFFFF, 64'h0);
            w_q.delete();
          end
        end
      end else if (w_out_ready) begin
        w_res.push_back(w_mcrc[15:0]);
        w_pending = 1'b0;
      end
    end
  end

  task automatic random_ready();
    out_ready   = ($urandom_range(0, 3) != 0);
    w_out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat (after an optional idle gap) and holds it until the
  // engine has accepted it.
  task automatic applyStimulus(input bit sel, input logic [15:0] d, input bit last,
                               input int gap, input bit rnd);
    int tmo;
    for (int g = 0; g < gap; g++) begin
      if (rnd) random_ready();
      cycle();
    end
    if (sel) begin
      w_valid = 1'b1; w_data = d; w_last = last;
    end else begin
      in_valid = 1'b1; in_data = d[7:0]; in_last = last;
    end
    tmo = 0;
    while (!(sel ? w_in_ready : dut_in_ready)) begin
      if (rnd) random_ready();
      cycle();
      tmo++;
      if (tmo > 200) begin
        $display("[TB] FAIL accept_timeout: got in_ready 0, expected 1 within 200 cycles");
        $fatal(1, "[TB] stalled");
      end
    end
    cycle();
    in_valid = 1'b0; in_last = 1'b0;
    w_valid  = 1'b0; w_last  = 1'b0;
  endtask

  task automatic send_bytes(input int off, input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, {8'h00, stim[off+i]}, (i == n - 1),
                    rnd ? int'($urandom_range(0, 2)) : 0, rnd);
  endtask

  task automatic send_words(input int off, input int n, input bit rnd);
    for (int i = 0; i < n / 2; i++)
      applyStimulus(1'b1, {stim[off+2*i], stim[off+2*i+1]}, (i == n / 2 - 1),
                    rnd ? int'($urandom_range(0, 2)) : 0, rnd);
  endtask

  // Opens the result port and waits until the pending result is taken.
  task automatic finish_frame(input bit sel);
    int tmo;
    out_ready   = 1'b1;
    w_out_ready = 1'b1;
    tmo = 0;
    while (!(sel ? w_out_valid : dut_out_valid)) begin
      cycle();
      tmo++;
      if (tmo > 50) begin
        $display("[TB] FAIL result_timeout: got out_valid 0, expected 1 within 50 cycles");
        $fatal(1, "[TB] stalled");
      end
    end
    cycle();
  endtask

  task automatic clear_lits();
    lit_en16 = 0; lit_en_i0 = 0; lit_en32 = 0; lit_en_len = 0; lit_en_l3 = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) stim[i] = 8'h00;
    for (int i = 0; i < 9; i++) stim[i] = 8'h31 + 8'(i);
    for (int i = 0; i < 10; i++) stim[10+i] = 8'hA0 + 8'(i);
    stim[60] = 8'h01;
    stim[61] = 8'h00;

    repeat (3) cycle();
    mon_en = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // "123456789" on all four byte-wide engines.
    $display("[TB] check string frame");
    lit_c16 = 64'h29B1; lit_ci0 = 64'h31C3; lit_c32 = 64'h0376E6E7;
    lit_len = 9; lit_l3 = 7;
    lit_en16 = 1; lit_en_i0 = 1; lit_en32 = 1; lit_en_len = 1; lit_en_l3 = 1;
    send_bytes(0, 9, 1'b0);
    finish_frame(1'b0);
    clear_lits();

    // Single-byte frames on the INIT=0 engine.
    lit_ci0 = 64'h1021; lit_en_i0 = 1;
    send_bytes(60, 1, 1'b0);
    finish_frame(1'b0);
    lit_ci0 = 64'h0000;
    send_bytes(61, 1, 1'b0);
    finish_frame(1'b0);
    clear_lits();

    // Back-pressure: result held for several cycles while beats are offered.
    $display("[TB] back-pressure");
    lit_c16 = 64'h29B1; lit_len = 9; lit_en16 = 1; lit_en_len = 1;
    out_ready = 1'b0;
    send_bytes(0, 9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h55;
      cycle();
    end
    in_valid = 1'b0;
    finish_frame(1'b0);
    send_bytes(0, 9, 1'b0);
    finish_frame(1'b0);

    // clr with a valid beat after four beats, then a full frame.
    $display("[TB] abort mid-frame");
    send_bytes(0, 4, 1'b0);
    in_valid = 1'b1; in_data = 8'h35; clr = 1'b1;
    cycle();
    clr = 1'b0; in_valid = 1'b0;
    send_bytes(0, 9, 1'b0);
    finish_frame(1'b0);
    clear_lits();

    // clr while a result is pending.
    out_ready = 1'b0;
    send_bytes(10, 9, 1'b0);
    repeat (2) cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (2) cycle();
    out_ready = 1'b1;
    cycle();

    // Reset mid-frame, then a fresh frame.
    $display("[TB] reset mid-frame");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, {8'h00, stim[i]}, 1'b0, 0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (2) cycle();
    lit_c16 = 64'h29B1; lit_len = 9; lit_en16 = 1; lit_en_len = 1;
    send_bytes(0, 9, 1'b0);
    finish_frame(1'b0);
    clear_lits();

    // Ten beats: LEN_W=3 saturates at 7, default counter reads 10.
    lit_len = 10; lit_l3 = 7; lit_en_len = 1; lit_en_l3 = 1;
    send_bytes(10, 10, 1'b0);
    finish_frame(1'b0);
    clear_lits();

    // Random frames: 16-bit beats first, then the same bytes 8 bits at a time.
    $display("[TB] random width equivalence");
    for (int f = 0; f < 4; f++) begin
      rand_off[f] = 20 + 10 * f;
      rand_len[f] = 2 * int'($urandom_range(1, 5));
      for (int i = 0; i < rand_len[f]; i++) stim[rand_off[f]+i] = 8'($urandom);
    end
    for (int f = 0; f < 4; f++) send_words(rand_off[f], rand_len[f], 1'b1);
    finish_frame(1'b1);
    eq_phase = 1'b1;
    for (int f = 0; f < 4; f++) send_bytes(rand_off[f], rand_len[f], 1'b1);
    finish_frame(1'b0);
    eq_phase = 1'b0;

    repeat (3) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised, clocked CRC engine that folds a framed data stream into a CRC, DATA_W bits per accepted beat, and presents the finished CRC (after final XOR) on a valid/ready output port. It generalises the fixed 8-bit-in, CRC-16/0x1021 combinational step to any CRC width, polynomial, init value, output XOR and beat width. It adds framing, back-pressure, abort and a beat counter. Polynomial, shift direction (left) and bit order (non-reflected) match the existing CRC-16 datapath.

## Interface
- CRC_W, 16, CRC width in bits (8..64)
- POLY, 16'h1021, generator polynomial, implicit x^CRC_W term omitted
- INIT, 16'hFFFF, register value at frame start
- XOR_OUT, 16'h0000, XORed into the register to form out_crc
- DATA_W, 8, bits consumed per beat (1..64); bit DATA_W-1 is processed first
- LEN_W, 16, width of the beat counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous abort of the current frame
- in_valid  in  1  beat present
- in_ready  out  1  engine accepts a beat this cycle
- in_data  in  DATA_W  beat payload
- in_last  in  1  beat is the final beat of the frame
- out_valid  out  1  result pending
- out_ready  in  1  consumer takes the result
- out_crc  out  CRC_W  final CRC, equal to reg ^ XOR_OUT
- out_len  out  LEN_W  beats in the frame, saturating at all-ones

## Operation
- Two states: ACCUM and DONE.
- ACCUM behaviour:
  - in_ready=1 and out_valid=0.
  - On accept (in_valid&in_ready), reg <= step(reg, in_data) and cnt <= sat(cnt+1).
  - If in_last is also set, out_crc/out_len are registered from the new values, and the state goes to DONE.
- DONE behaviour:
  - in_ready=0 and out_valid=1.
  - out_crc and out_len are held stable until out_ready.
  - On out_ready, the state goes to ACCUM with reg <= INIT and cnt <= 0.
- step(): the DATA_W-iteration unrolled MSB-first LFSR update.
  - For each bit: fb = reg[CRC_W-1] ^ d[i]; reg = (reg<<1) ^ (fb ? POLY : 0).
  - Purely combinational; no loop-carried registers.
- clr, any state:
  - reg <= INIT, cnt <= 0, state <= ACCUM, out_valid <= 0.
  - A beat presented in the same cycle is dropped; in_ready is still 1 in ACCUM, so the upstream considers it consumed.
  - A pending result is discarded.
- rst has the same effect as clr and also zeroes out_crc and out_len.
- cnt saturates at 2^LEN_W-1 and never wraps; the CRC is unaffected by saturation.
- Zero-length frames do not exist; every frame contains at least one beat (the in_last beat).

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_crc=0, out_len=0.
  - Internal reg=INIT, state=ACCUM.
- Throughput: one beat per cycle in ACCUM.
- Latency: a last beat accepted on cycle N gives out_valid=1 from cycle N+1.
- Frame-to-frame bubble:
  - With out_ready held high, DONE lasts exactly one cycle; in_ready returns on N+2.
  - Minimum frame period is therefore beats+1 cycles.
- in_ready depends only on registered state, never combinationally on in_valid or out_ready.
- out_valid/out_crc/out_len are registered outputs.
- Simultaneous out_ready and clr in DONE: clr wins; the result is not counted as delivered.
- rst asserted mid-frame: the partial frame is lost, and the first post-reset beat starts a fresh frame.

## Structure
- Package crc_pkg holds:
  - function crc_step(crc, data, poly), parametrised by width; shared with the existing combinational CRC blocks.
  - Standard polynomial/init constants: CRC16_CCITT 0x1021, CRC32 0x04C11DB7.
  - The state enum.
- One sub-module, crc_step_comb, wraps crc_step as a combinational block.
  - The DATA_W=8, CRC_W=16, POLY=0x1021 instance must be bit-equivalent to the legacy CRC-16 step.
- The top holds the FSM, counter and output registers; estimated 150-250 lines total.

## Test plan
- Default params, bytes "123456789" (0x31..0x39), in_last on 0x39 → out_crc=0x29B1, out_len=9, out_valid one cycle after the last accept.
- INIT=0, same 9 bytes → 0x31C3; single byte 0x01 → 0x1021; single byte 0x00 → 0x0000.
- CRC_W=32, POLY=0x04C11DB7, INIT=0xFFFFFFFF, same 9 bytes → 0x0376E6E7.
- Back-pressure:
  - Hold out_ready=0 for 5 cycles after a frame.
  - Required: in_ready=0 throughout, out_crc stable, no beat consumed.
  - Then a second "123456789" frame → 0x29B1 again.
- clr injected:
  - Assert clr after 4 beats together with a valid beat, then send the full 9 bytes.
  - Required: 0x29B1, out_len=9.
  - clr during DONE: out_valid drops the next cycle.
- Randomised equivalence:
  - DATA_W=16 versus DATA_W=8 on the same byte stream, fed high byte first, with random in_valid/out_ready gaps.
  - Required: identical out_crc.
  - Separately, LEN_W=3 with 10 beats → out_len=7.
